btn_event_gen: RTL and testbench
================================

BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100_000: stable-input cycles needed to accept a level change (10 ms at 10 MHz); legal range 2 or more.
REQ-002 SHALL have parameter REPEAT_DELAY, default 5_000_000: held cycles from the accepted press to the first auto-repeat event; legal range 2 or more.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2_000_000: cycles between successive auto-repeat events; legal range 2 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_in, input, 4 bits: raw asynchronous buttons; bit0 animation+, bit1 animation-, bit2 speed+, bit3 speed-.
REQ-007 SHALL have port evt, output, 4 bits: registered single-cycle event pulse per button.
REQ-008 SHALL have port level, output, 4 bits: registered debounced button level.

Function
REQ-009 SHALL pass each btn_in bit through a 2-flop synchronizer before any other logic.
REQ-010 SHALL run one FSM per channel with states IDLE, DB_PRESS, HOLD_DELAY, HOLD_REPEAT and DB_RELEASE, each with its own counter sized to $clog2 of the largest parameter.
REQ-011 IDLE: SHALL move to DB_PRESS with the counter cleared when the synced input is 1.
REQ-012 DB_PRESS: SHALL return to IDLE on input 0, and SHALL enter HOLD_DELAY once the counter reaches DEBOUNCE_CYCLES-1, firing one press event.
REQ-013 Press latency: with btn_in sampled high first at edge N and held, evt SHALL be high for exactly the cycle after edge N+DEBOUNCE_CYCLES+2.
REQ-014 HOLD_DELAY: SHALL enter HOLD_REPEAT after REPEAT_DELAY cycles, firing one event.
REQ-015 HOLD_REPEAT: SHALL fire one event every REPEAT_PERIOD cycles while held.
REQ-016 HOLD_DELAY or HOLD_REPEAT: SHALL enter DB_RELEASE with the counter cleared on input 0.
REQ-017 DB_RELEASE: SHALL return to HOLD_DELAY with the counter cleared and no event on input 1, and SHALL enter IDLE after DEBOUNCE_CYCLES consecutive input-0 cycles.
REQ-018 level SHALL be 1 exactly while the FSM is in HOLD_DELAY, HOLD_REPEAT or DB_RELEASE.
REQ-019 Pair conflict: if both channels of a pair ({0,1} or {2,3}) would fire in the same cycle, both evt bits of that pair SHALL be 0 that cycle; the channel FSMs are unaffected.
REQ-020 Channels SHALL be fully independent apart from REQ-019.
REQ-021 evt SHALL never be high for two consecutive cycles on the same bit.

Reset
REQ-022 rst_n low SHALL immediately force evt=0, level=0, all FSMs to IDLE, and all counters and synchronizer flops to 0.
REQ-023 Reset asserted mid-press SHALL discard the press with no event; after release of reset, a still-held button SHALL be treated as a new press with the full REQ-013 latency.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN defined: SHALL give the behaviour of REQ-014 and REQ-015.
REQ-025 BTN_AUTOREPEAT_EN undefined: SHALL give exactly one event per accepted press, HOLD_DELAY SHALL persist until release, HOLD_REPEAT SHALL be unreachable, and REPEAT_DELAY/REPEAT_PERIOD SHALL be ignored.

Structure
REQ-026 Package btn_event_pkg SHALL hold the channel state enum, the default parameter constants and the channel index constants (ANI_INC=0, ANI_DEC=1, SPD_INC=2, SPD_DEC=3).
REQ-027 Sub-module btn_event_channel SHALL implement one synchronizer plus FSM and SHALL be instantiated four times; btn_event_gen SHALL add only the pair-conflict masking and the output registers.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, macro defined unless stated)
REQ-028 Press: btn_in[0] high at edge 10 and held for 12 cycles -> evt[0] high only in the cycle after edge 16; level[0] rises in the same cycle.
REQ-029 Bounce: btn_in[2] toggles 1,0,1,0 at 1-cycle spacing, then stays 0 -> evt and level remain 0 throughout.
REQ-030 Auto-repeat: btn_in[1] held 60 cycles -> evt[1] pulses at relative cycles 6, 26, 34, 42, 50, 58.
REQ-031 Auto-repeat with macro undefined: same stimulus as REQ-030 -> a single evt[1] pulse at cycle 6.
REQ-032 Conflict: btn_in[2] and btn_in[3] rise on the same edge -> evt[3:2] stay 0, while level[3:2] both go 1 at cycle 6.
REQ-033 Reset mid-hold: rst_n pulled low 3 cycles into HOLD_DELAY and btn held -> outputs 0 immediately; after reset release, the next event arrives after the full press latency.

Source files
------------

// File: rtl/btn_event_pkg.sv
// Shared types and constants for the button event generator.
// Channel FSM state enum, default timing parameters and button index map.
package btn_event_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DB_PRESS,
      ST_HOLD_DELAY,
      ST_HOLD_REPEAT,
      ST_DB_RELEASE
   } chan_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 100_000;
   localparam int DEF_REPEAT_DELAY    = 5_000_000;
   localparam int DEF_REPEAT_PERIOD   = 2_000_000;

   localparam int NUM_BTN = 4;
   localparam int ANI_INC = 0;
   localparam int ANI_DEC = 1;
   localparam int SPD_INC = 2;
   localparam int SPD_DEC = 3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/btn_event_channel.sv
// One button channel: 2-flop synchronizer, debounce and hold/auto-repeat FSM.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_event_channel
   import btn_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic fire,
   output logic level_next
);

   localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

   logic [1:0]       sync_q;
   logic             btn_s;
   chan_state_e      state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         state  <= ST_IDLE;
         cnt    <= '0;
      end else begin
         sync_q <= {sync_q[0], btn_raw};
         state  <= state_next;
         cnt    <= cnt_next;
      end
   end

   assign btn_s = sync_q[1];

   // NOTE: both outputs get a default before the case so no path leaves them
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt + CNT_W'(1);
      unique case (state)
         ST_IDLE: begin
            cnt_next = '0;
            if (btn_s) state_next = ST_DB_PRESS;
         end
         ST_DB_PRESS: begin
            if (!btn_s) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt == DB_LAST) begin
               state_next = ST_HOLD_DELAY;
               cnt_next   = '0;
            end
         end
         ST_HOLD_DELAY: begin
            if (!btn_s) begin
               state_next = ST_DB_RELEASE;
               cnt_next   = '0;
`ifdef BTN_AUTOREPEAT_EN
            end else if (cnt == RD_LAST) begin
               state_next = ST_HOLD_REPEAT;
               cnt_next   = '0;
`else
            end else begin
               cnt_next = cnt;
`endif
            end
         end
`ifdef BTN_AUTOREPEAT_EN
         ST_HOLD_REPEAT: begin
            if (!btn_s) begin
               state_next = ST_DB_RELEASE;
               cnt_next   = '0;
            end else if (cnt == RP_LAST) begin
               cnt_next = '0;
            end
         end
`endif
         ST_DB_RELEASE: begin
            // A bounce back to 1 restarts the full repeat delay.
            if (btn_s) begin
               state_next = ST_HOLD_DELAY;
               cnt_next   = '0;
            end else if (cnt == DB_LAST) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_comb begin
      fire = btn_s && (state == ST_DB_PRESS) && (cnt == DB_LAST);
`ifdef BTN_AUTOREPEAT_EN
      fire = fire
           || (btn_s && (state == ST_HOLD_DELAY)  && (cnt == RD_LAST))
           || (btn_s && (state == ST_HOLD_REPEAT) && (cnt == RP_LAST));
`endif
      level_next = (state_next == ST_HOLD_DELAY)
                || (state_next == ST_HOLD_REPEAT)
                || (state_next == ST_DB_RELEASE);
   end

endmodule

// File: rtl/btn_event_gen.sv
// Four debounced button channels with pair-conflict masking and registered outputs.
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat events.
module btn_event_gen
   import btn_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_BTN-1:0]   btn_in,
   output logic [NUM_BTN-1:0]   evt,
   output logic [NUM_BTN-1:0]   level
);

   logic [NUM_BTN-1:0] fire;
   logic [NUM_BTN-1:0] level_next;
   logic [NUM_BTN-1:0] partner_fire;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_event_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .btn_raw    (btn_in[i]),
         .fire       (fire[i]),
         .level_next (level_next[i])
      );
   end

   // Opposing buttons of a pair cancel each other when they fire together.
   always_comb begin
      partner_fire          = '0;
      partner_fire[ANI_INC] = fire[ANI_DEC];
      partner_fire[ANI_DEC] = fire[ANI_INC];
      partner_fire[SPD_INC] = fire[SPD_DEC];
      partner_fire[SPD_DEC] = fire[SPD_INC];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt   <= '0;
         level <= '0;
      end else begin
         evt   <= fire & ~partner_fire;
         level <= level_next;
      end
   end

endmodule

// File: tb/tb_btn_event_gen.sv
// Self-checking bench for btn_event_gen: directed scenarios plus randomized
// button traffic compared every cycle against a run-length behavioural model.
module tb_btn_event_gen;

   localparam int D = 4;
   localparam int R = 20;
   localparam int P = 8;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] btn_in;
   logic [3:0] evt;
   logic [3:0] level;

   int n_pass  = 0;
   int n_total = 0;

   btn_event_gen #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (R),
      .REPEAT_PERIOD   (P)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (btn_in),
      .evt    (evt),
      .level  (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: run lengths of the 2-cycle-delayed input decide
   // acceptance, release and the repeat schedule.
   bit   m_p1[4], m_p2[4], m_lvl[4];
   int   m_run1[4], m_run0[4], m_age[4], m_due[4];
   logic [3:0] exp_evt, exp_lvl;

   task automatic model_step();
      logic [3:0] f;
      bit s;
      f = '0;
      if (!rst_n) begin
         for (int c = 0; c < 4; c++) begin
            m_p1[c] = 0; m_p2[c] = 0; m_lvl[c] = 0;
            m_run1[c] = 0; m_run0[c] = 0; m_age[c] = 0; m_due[c] = R;
         end
         exp_evt = '0;
         exp_lvl = '0;
         return;
      end
      for (int c = 0; c < 4; c++) begin
         s = m_p2[c];
         m_p2[c] = m_p1[c];
         m_p1[c] = btn_in[c];
         if (!m_lvl[c]) begin
            if (s) begin
               m_run1[c]++;
               if (m_run1[c] == D + 1) begin
                  f[c] = 1'b1; m_lvl[c] = 1; m_age[c] = 0; m_due[c] = R; m_run0[c] = 0;
               end
            end else m_run1[c] = 0;
         end else if (!s) begin
            m_run0[c]++;
            if (m_run0[c] == D + 1) begin
               m_lvl[c] = 0; m_run1[c] = 0;
            end
         end else if (m_run0[c] > 0) begin
            m_run0[c] = 0; m_age[c] = 0; m_due[c] = R;
         end else begin
            m_age[c]++;
            if (AUTO && m_age[c] == m_due[c]) begin
               f[c] = 1'b1; m_age[c] = 0; m_due[c] = P;
            end
         end
      end
      exp_evt = f & ~{f[2], f[3], f[0], f[1]};
      exp_lvl = {m_lvl[3], m_lvl[2], m_lvl[1], m_lvl[0]};
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #3;
         check("evt_model", 128'(evt), 128'(exp_evt));
         check("level_model", 128'(level), 128'(exp_lvl));
      end
   end

   logic [3:0] stim[100];
   logic [3:0] ev_log[100];
   logic [3:0] lv_log[100];

   task automatic clear_stim();
      for (int k = 0; k < 100; k++) stim[k] = 4'h0;
   endtask

   // Edge k of the run samples stim[k]; outputs logged just after edge k.
   task automatic run(input int n);
      @(negedge clk);
      btn_in = stim[0];
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #3;
         ev_log[k] = evt;
         lv_log[k] = level;
         @(negedge clk);
         btn_in = (k + 1 < n) ? stim[k + 1] : 4'h0;
      end
   endtask

   function automatic int count_hi(input int b, input int n, input bit use_lvl);
      int cnt = 0;
      for (int k = 0; k < n; k++) cnt += use_lvl ? int'(lv_log[k][b]) : int'(ev_log[k][b]);
      return cnt;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [69:0] act_rep, exp_rep;
      logic [3:0]  nb;
      int          rem[4];
      int          rst_hold;
      bit          mirror;

      btn_in = 4'h0;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single press held 12 cycles.
      clear_stim();
      for (int k = 0; k < 12; k++) stim[k][0] = 1'b1;
      run(30);
      check("press_evt_at_6", 128'(ev_log[6][0]), 128'(1));
      check("press_evt_count", 128'(count_hi(0, 30, 0)), 128'(1));
      check("press_lvl_before", 128'(lv_log[5][0]), 128'(0));
      check("press_lvl_rise", 128'(lv_log[6][0]), 128'(1));
      check("press_lvl_fall", 128'({lv_log[17][0], lv_log[18][0]}), 128'(2'b10));

      // Bounce shorter than the debounce window.
      clear_stim();
      stim[0][2] = 1'b1;
      stim[2][2] = 1'b1;
      run(20);
      check("bounce_evt", 128'(count_hi(2, 20, 0)), 128'(0));
      check("bounce_lvl", 128'(count_hi(2, 20, 1)), 128'(0));

      // Long hold: auto-repeat schedule.
      clear_stim();
      for (int k = 0; k < 60; k++) stim[k][1] = 1'b1;
      run(70);
      act_rep = '0;
      exp_rep = '0;
      for (int k = 0; k < 70; k++) act_rep[k] = ev_log[k][1];
      exp_rep[6] = 1'b1;
      if (AUTO) begin
         exp_rep[26] = 1'b1; exp_rep[34] = 1'b1; exp_rep[42] = 1'b1;
         exp_rep[50] = 1'b1; exp_rep[58] = 1'b1;
      end
      check("repeat_pulses", 128'(act_rep), 128'(exp_rep));
      check("repeat_lvl_release", 128'({lv_log[65][1], lv_log[66][1]}), 128'(2'b10));

      // Same-pair conflict.
      clear_stim();
      for (int k = 0; k < 12; k++) stim[k] = 4'b1100;
      run(30);
      check("conflict_evt2", 128'(count_hi(2, 30, 0)), 128'(0));
      check("conflict_evt3", 128'(count_hi(3, 30, 0)), 128'(0));
      check("conflict_lvl_before", 128'(lv_log[5][3:2]), 128'(2'b00));
      check("conflict_lvl_at_6", 128'(lv_log[6][3:2]), 128'(2'b11));

      // Reset three cycles into the hold, button kept pressed.
      @(negedge clk);
      btn_in = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #3;
         ev_log[k] = evt;
         lv_log[k] = level;
      end
      check("mid_hold_lvl_pre", 128'(lv_log[9][0]), 128'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_evt_now", 128'(evt), 128'(0));
      check("reset_lvl_now", 128'(level), 128'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #3;
         ev_log[k] = evt;
         lv_log[k] = level;
      end
      check("reset_repress_at_6", 128'(ev_log[6][0]), 128'(1));
      check("reset_repress_count", 128'(count_hi(0, 20, 0)), 128'(1));
      check("reset_repress_lvl", 128'({lv_log[5][0], lv_log[6][0]}), 128'(2'b01));
      @(negedge clk);
      btn_in = 4'h0;
      repeat (20) @(negedge clk);

      // Randomized traffic with occasional resets and mirrored pairs.
      for (int c = 0; c < 4; c++) rem[c] = 0;
      rst_hold = 0;
      mirror   = 1'b0;
      nb       = 4'h0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (rst_hold > 0) begin
            rst_hold--;
            rst_n = (rst_hold == 0);
         end else if ($urandom_range(0, 799) == 0) begin
            rst_n    = 1'b0;
            rst_hold = 2;
         end
         if (cyc % 250 == 0) mirror = 1'($urandom_range(0, 1));
         for (int c = 0; c < 4; c++) begin
            if (rem[c] == 0) begin
               nb[c]  = 1'($urandom_range(0, 1));
               rem[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 70);
            end
            rem[c]--;
         end
         if (mirror) begin
            nb[1] = nb[0];
            nb[3] = nb[2];
         end
         btn_in = nb;
      end
      @(negedge clk);
      rst_n  = 1'b1;
      btn_in = 4'h0;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
